// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying words read back from the block RAM.
// The reader drives the master side; downstream compute is the slave.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Read engine for a simple-dual-port block RAM: issues a contiguous address run,
// absorbs the fixed read latency and streams the returned words with backpressure.
module bram_stream_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    bram_stream_reader_if.master  strm
);
    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] ONE_WORD = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [READ_LATENCY:0] iss_sr;
    logic [READ_LATENCY:0] last_sr;
    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  accept;
    logic                  issue;
    logic                  issue_last;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic [ADDR_WIDTH-1:0] issue_addr;
    entry_t                head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        accept     = start && (state == IDLE || state == FINISH);
        push       = iss_sr[READ_LATENCY];
        pop        = strm.out_valid && strm.out_ready;
        credit_ok  = (int'(fifo_count) + $countones(iss_sr) - int'(pop)) < FIFO_DEPTH;
        issue_addr = (state == ISSUE) ? next_addr : base_addr;
        issue      = 1'b0;
        issue_last = 1'b0;
        if (accept && length != '0) begin
            issue      = 1'b1;
            issue_last = (length == ONE_WORD);
        end else if (state == ISSUE && remaining != '0 && credit_ok) begin
            issue      = 1'b1;
            issue_last = (remaining == ONE_WORD);
        end
    end

    // The head entry is only meaningful while the FIFO holds data; outputs read 0 otherwise.
    always_comb begin
        head           = fifo_mem[rd_ptr];
        strm.out_valid = (fifo_count != '0);
        strm.out_data  = strm.out_valid ? head.data : '0;
        strm.out_last  = strm.out_valid && head.last;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdaddress  <= '0;
            next_addr  <= '0;
            remaining  <= '0;
            iss_sr     <= '0;
            last_sr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            iss_sr  <= {iss_sr[READ_LATENCY-1:0], issue};
            last_sr <= {last_sr[READ_LATENCY-1:0], issue_last};

            if (issue) begin
                rdaddress <= issue_addr;
                next_addr <= issue_addr + 1'b1;
            end

            // NOTE: FIFO storage is not reset; the output mux masks it until an entry is written.
            if (push) begin
                fifo_mem[wr_ptr] <= '{last: last_sr[READ_LATENCY], data: q};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;

            done <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (accept) begin
                        if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            remaining <= length - 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) remaining <= remaining - 1'b1;
                    if (remaining == '0 || (issue && issue_last)) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && strm.out_last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit accounting must keep every returned word inside the FIFO.
    fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule
